// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning HI/LO: iterative MULT/MULTU/DIVU (one bit per cycle) plus MTHI/MTLO/MFHI/MFLO.
// Optional macro MULDIV_SINGLE_CYCLE_MUL_EN swaps the iterative multiply for a one-cycle combinational one.
`ifndef ALU_CONTROL_LENGTH
`define ALU_CONTROL_LENGTH 5
`endif
`ifndef ALU_CONTROL_NOP
`define ALU_CONTROL_NOP 5'd0
`endif
`ifndef ALU_CONTROL_MULT
`define ALU_CONTROL_MULT 5'd13
`endif
`ifndef ALU_CONTROL_MULTU
`define ALU_CONTROL_MULTU 5'd14
`endif
`ifndef ALU_CONTROL_DIVU
`define ALU_CONTROL_DIVU 5'd15
`endif
`ifndef ALU_CONTROL_MFHI
`define ALU_CONTROL_MFHI 5'd16
`endif
`ifndef ALU_CONTROL_MFLO
`define ALU_CONTROL_MFLO 5'd17
`endif
`ifndef ALU_CONTROL_MTHI
`define ALU_CONTROL_MTHI 5'd18
`endif
`ifndef ALU_CONTROL_MTLO
`define ALU_CONTROL_MTLO 5'd19
`endif

module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [`ALU_CONTROL_LENGTH-1:0] alu_control,
  input  logic [XLEN-1:0]                src_a,
  input  logic [XLEN-1:0]                src_b,
  input  logic                           flush,
  output logic                           busy,
  output logic                           done,
  output logic [XLEN-1:0]                hilo_rdata,
  output logic [XLEN-1:0]                hi,
  output logic [XLEN-1:0]                lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_acc_hi;
  logic [XLEN-1:0]     r_acc_lo;
  logic [XLEN-1:0]     r_opnd;
  logic                r_is_div;
  logic                r_neg;
  logic [XLEN-1:0]     r_hi;
  logic [XLEN-1:0]     r_lo;
  logic                r_done;

  logic                w_is_mult;
  logic                w_is_mul;
  logic                w_is_div;
  logic                w_accept;
  logic                w_go_run;
  logic [XLEN:0]       w_sum;
  logic [XLEN:0]       w_madd;
  logic [2*XLEN-1:0]   w_mul_step;
  logic [XLEN:0]       w_shrem;
  logic [XLEN:0]       w_trial;
  logic                w_div_ok;
  logic [2*XLEN-1:0]   w_div_step;
  logic [2*XLEN-1:0]   w_step;
  logic [2*XLEN-1:0]   w_final;

  assign w_is_mult = (alu_control == `ALU_CONTROL_MULT);
  assign w_is_mul  = w_is_mult || (alu_control == `ALU_CONTROL_MULTU);
  assign w_is_div  = (alu_control == `ALU_CONTROL_DIVU);
  // flush in IDLE cancels any same-cycle request, including MTHI/MTLO
  assign w_accept  = (r_state == S_IDLE) && start && !flush;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  logic [2*XLEN-1:0] w_ext_a;
  logic [2*XLEN-1:0] w_ext_b;
  logic [2*XLEN-1:0] w_prod;

  assign w_ext_a  = w_is_mult ? {{XLEN{src_a[XLEN-1]}}, src_a} : {{XLEN{1'b0}}, src_a};
  assign w_ext_b  = w_is_mult ? {{XLEN{src_b[XLEN-1]}}, src_b} : {{XLEN{1'b0}}, src_b};
  assign w_prod   = w_ext_a * w_ext_b;
  assign w_go_run = w_accept && w_is_div;
`else
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_neg;

  // 0x80000000 negates to itself, which read unsigned is the wanted 2^31
  assign w_abs_a  = (w_is_mult && src_a[XLEN-1]) ? -src_a : src_a;
  assign w_abs_b  = (w_is_mult && src_b[XLEN-1]) ? -src_b : src_b;
  assign w_neg    = w_is_mult && (src_a[XLEN-1] ^ src_b[XLEN-1]);
  assign w_go_run = w_accept && (w_is_mul || w_is_div);
`endif

  // Shift-add: multiplier sits in acc_lo and drains out the bottom as product bits shift in
  assign w_sum      = {1'b0, r_acc_hi} + {1'b0, r_opnd};
  assign w_madd     = r_acc_lo[0] ? w_sum : {1'b0, r_acc_hi};
  assign w_mul_step = {w_madd, r_acc_lo[XLEN-1:1]};

  // Restoring divide: a set top bit in the shifted remainder always beats the divisor
  assign w_shrem    = {r_acc_hi, r_acc_lo[XLEN-1]};
  assign w_trial    = w_shrem - {1'b0, r_opnd};
  assign w_div_ok   = w_shrem[XLEN] || !w_trial[XLEN];
  assign w_div_step = {(w_div_ok ? w_trial[XLEN-1:0] : w_shrem[XLEN-1:0]),
                       r_acc_lo[XLEN-2:0], w_div_ok};

  assign w_step  = r_is_div ? w_div_step : w_mul_step;
  assign w_final = r_neg ? -w_step : w_step;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_go_run) w_state_nxt = S_RUN;
      S_RUN:  if (flush || (r_cnt == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          case (alu_control)
            `ALU_CONTROL_MTHI: r_hi <= src_a;
            `ALU_CONTROL_MTLO: r_lo <= src_a;
            `ALU_CONTROL_MULT, `ALU_CONTROL_MULTU: begin
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
              r_hi   <= w_prod[2*XLEN-1:XLEN];
              r_lo   <= w_prod[XLEN-1:0];
              r_done <= 1'b1;
`else
              r_cnt    <= CNT_W'(XLEN - 1);
              r_acc_hi <= '0;
              r_acc_lo <= w_abs_b;
              r_opnd   <= w_abs_a;
              r_is_div <= 1'b0;
              r_neg    <= w_neg;
`endif
            end
            `ALU_CONTROL_DIVU: begin
              r_cnt    <= CNT_W'(XLEN - 1);
              r_acc_hi <= '0;
              r_acc_lo <= src_a;
              r_opnd   <= src_b;
              r_is_div <= 1'b1;
              r_neg    <= 1'b0;
            end
            default: ;
          endcase
        end
      end else if (!flush) begin
        r_acc_hi <= w_step[2*XLEN-1:XLEN];
        r_acc_lo <= w_step[XLEN-1:0];
        r_cnt    <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_hi   <= w_final[2*XLEN-1:XLEN];
          r_lo   <= w_final[XLEN-1:0];
          r_done <= 1'b1;
        end
      end
    end
  end

  // MFHI/MFLO read the architectural registers, never the in-flight accumulator
  always_comb begin
    hilo_rdata = '0;
    if (alu_control == `ALU_CONTROL_MFHI)      hilo_rdata = r_hi;
    else if (alu_control == `ALU_CONTROL_MFLO) hilo_rdata = r_lo;
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized back-to-back
// MULT/MULTU/DIVU against a plain-arithmetic reference model.
`ifndef ALU_CONTROL_LENGTH
`define ALU_CONTROL_LENGTH 5
`endif
`ifndef ALU_CONTROL_NOP
`define ALU_CONTROL_NOP 5'd0
`endif
`ifndef ALU_CONTROL_MULT
`define ALU_CONTROL_MULT 5'd13
`endif
`ifndef ALU_CONTROL_MULTU
`define ALU_CONTROL_MULTU 5'd14
`endif
`ifndef ALU_CONTROL_DIVU
`define ALU_CONTROL_DIVU 5'd15
`endif
`ifndef ALU_CONTROL_MFHI
`define ALU_CONTROL_MFHI 5'd16
`endif
`ifndef ALU_CONTROL_MFLO
`define ALU_CONTROL_MFLO 5'd17
`endif
`ifndef ALU_CONTROL_MTHI
`define ALU_CONTROL_MTHI 5'd18
`endif
`ifndef ALU_CONTROL_MTLO
`define ALU_CONTROL_MTLO 5'd19
`endif

module tb_muldiv_unit;
  localparam int AW = `ALU_CONTROL_LENGTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] alu_control;
  logic [31:0]   src_a;
  logic [31:0]   src_b;
  logic          flush;
  logic          busy;
  logic          done;
  logic [31:0]   hilo_rdata;
  logic [31:0]   hi;
  logic [31:0]   lo;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy), .done(done),
    .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // reference model: architectural result {HI, LO} straight from integer arithmetic
  function automatic logic [63:0] ref_result(input logic [AW-1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] r;
    r = '0;
    if (op == `ALU_CONTROL_MULTU) begin
      r = {32'h0, a} * {32'h0, b};
    end else if (op == `ALU_CONTROL_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = 64'(sa * sb);
    end else if (op == `ALU_CONTROL_DIVU) begin
      if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
      else            r = {a % b, a / b};
    end
    return r;
  endfunction

  // driver: issue one mul/div, follow it cycle by cycle; flush_at>0 aborts it in cycle T+flush_at
  task automatic run_op(input logic [AW-1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    int lat;
    logic [63:0] e;
    lat = 33;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    if (op != `ALU_CONTROL_DIVU) lat = 1;
`endif
    if (flush_at == 0) exp_q.push_back(ref_result(op, a, b));
    start = 1'b1; alu_control = op; src_a = a; src_b = b;
    tick();
    start = 1'b0; alu_control = `ALU_CONTROL_NOP; src_a = $urandom; src_b = $urandom;
    for (int k = 1; k <= lat; k++) begin
      if (flush_at != 0 && k == flush_at + 1) begin
        flush = 1'b0;
        check("flush_flags", {62'h0, busy, done}, 64'h0);
        check("flush_hilo", {hi, lo}, {m_hi, m_lo});
        tick();
        check("flush_nodone", {63'h0, done}, 64'h0);
        return;
      end
      if (k < lat) begin
        check("run_flags", {62'h0, busy, done}, 64'h2);
      end else begin
        check("done_flags", {62'h0, busy, done}, 64'h1);
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 64'h0, 64'h1);
        end else begin
          e = exp_q.pop_front();
          check("result", {hi, lo}, e);
          m_hi = e[63:32];
          m_lo = e[31:0];
        end
      end
      // a stray MTHI while busy must be ignored
      start       = (k == 5) && (k < lat);
      alu_control = start ? `ALU_CONTROL_MTHI : `ALU_CONTROL_NOP;
      src_a       = $urandom;
      flush       = (k == flush_at);
      if (k < lat) tick();
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic mt(input logic [AW-1:0] op, input logic [31:0] v);
    start = 1'b1; alu_control = op; src_a = v;
    tick();
    start = 1'b0; alu_control = `ALU_CONTROL_NOP;
    if (op == `ALU_CONTROL_MTHI) m_hi = v;
    else                         m_lo = v;
    check("mt_flags", {62'h0, busy, done}, 64'h0);
    check("mt_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic readback();
    alu_control = `ALU_CONTROL_MFHI; #1;
    check("mfhi", {32'h0, hilo_rdata}, {32'h0, m_hi});
    alu_control = `ALU_CONTROL_MFLO; #1;
    check("mflo", {32'h0, hilo_rdata}, {32'h0, m_lo});
    alu_control = `ALU_CONTROL_NOP; #1;
    check("rdata_other", {32'h0, hilo_rdata}, 64'h0);
  endtask

  initial begin
    logic [AW-1:0] op;
    logic [31:0]   a;
    logic [31:0]   b;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    alu_control = `ALU_CONTROL_NOP; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) begin
      start = 1'b1; alu_control = `ALU_CONTROL_MTHI; src_a = $urandom;
      tick();
    end
    check("reset_flags", {62'h0, busy, done}, 64'h0);
    check("reset_hilo", {hi, lo}, 64'h0);
    rst = 1'b0; start = 1'b0; alu_control = `ALU_CONTROL_NOP;
    tick();
    check("post_reset_hilo", {hi, lo}, 64'h0);

    // directed corners
    run_op(`ALU_CONTROL_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); readback();
    run_op(`ALU_CONTROL_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 0); readback();
    run_op(`ALU_CONTROL_MULT,  32'h8000_0000, 32'h8000_0000, 0); readback();
    run_op(`ALU_CONTROL_DIVU,  32'd100,       32'd7,         0); readback();
    run_op(`ALU_CONTROL_DIVU,  32'h1234_5678, 32'h0,         0); readback();

    mt(`ALU_CONTROL_MTHI, 32'hDEAD_BEEF);
    mt(`ALU_CONTROL_MTLO, 32'h0BAD_F00D);
    readback();

    // flush in IDLE suppresses a same-cycle MTHI
    start = 1'b1; flush = 1'b1; alu_control = `ALU_CONTROL_MTHI; src_a = 32'h1357_9BDF;
    tick();
    start = 1'b0; flush = 1'b0; alu_control = `ALU_CONTROL_NOP;
    check("idle_flush_hi", {32'h0, hi}, {32'h0, m_hi});

    // abort an in-flight divide, then run a fresh multiply
    mt(`ALU_CONTROL_MTHI, 32'h0000_AAAA);
    mt(`ALU_CONTROL_MTLO, 32'h0000_5555);
    run_op(`ALU_CONTROL_DIVU, $urandom, $urandom_range(1, 1000), 10);
    run_op(`ALU_CONTROL_MULTU, 32'd3, 32'd5, 0); readback();

    // reset in the middle of a MULT, with start pulses during reset
    start = 1'b1; alu_control = `ALU_CONTROL_MULT; src_a = $urandom; src_b = $urandom;
    tick();
    start = 1'b0; alu_control = `ALU_CONTROL_NOP;
    repeat (19) tick();
    rst = 1'b1; start = 1'b1; alu_control = `ALU_CONTROL_MTHI; src_a = $urandom;
    tick();
    check("midrst_flags", {62'h0, busy, done}, 64'h0);
    check("midrst_hilo", {hi, lo}, 64'h0);
    alu_control = `ALU_CONTROL_MTLO; src_a = $urandom;
    tick();
    rst = 1'b0; start = 1'b0; alu_control = `ALU_CONTROL_NOP;
    m_hi = '0; m_lo = '0;
    tick();
    check("after_rst_flags", {62'h0, busy, done}, 64'h0);
    check("after_rst_hilo", {hi, lo}, 64'h0);

    // randomized back-to-back traffic
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0:       op = `ALU_CONTROL_MULT;
        1:       op = `ALU_CONTROL_MULTU;
        default: op = `ALU_CONTROL_DIVU;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      run_op(op, a, b, 0);
      readback();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
